gbuff_arbiter: RTL and testbench

Round-robin access controller that shares one single-port global buffer among NUM_REQ requesters (DMA loader, PE-array feeders, result writer). Each cycle it grants at most one read or write, drives the buffer's write-enable/index/data ports, and returns read data with fixed one-cycle latency to the granted requester. An optional sweep engine zero-fills the whole buffer on command without a global reset.

---
 rtl/gbuff_arb_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/gbuff_arbiter.sv | 109 ++++++++++
 tb/tb_gbuff_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbuff_arb_pkg.sv
// Shared types and helpers for the global-buffer arbiter.
// Sweep engine is compiled in only when GBUFF_ARB_CLEAR_EN is defined.
package gbuff_arb_pkg;

   localparam int NUM_REQ_DEF   = 4;
   localparam int ADDR_BITS_DEF = 8;
   localparam int DATA_BITS_DEF = 8;

   typedef logic [0:0] state_t;

   localparam state_t SERVE = 1'b0;
   localparam state_t CLEAR = 1'b1;

   function automatic int req_id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority encoder: first valid requester at or above ptr,
// wrapping modulo N. Purely combinational; pointer lives in the parent.
module rr_arbiter
   import gbuff_arb_pkg::*;
#(
   parameter int N = NUM_REQ_DEF,
   parameter int W = req_id_w(N)
) (
   input  logic [N-1:0] valid,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] idx,
   output logic         any
);

   localparam int W1 = W + 1;

   logic [W1-1:0] s;
   logic [W-1:0]  j;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      s     = '0;
      j     = '0;
      for (int i = 0; i < N; i++) begin
         s = {1'b0, ptr} + W1'(i);
         if (s >= W1'(N)) s = s - W1'(N);
         j = s[W-1:0];
         if (!any && valid[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = j;
         end
      end
   end

endmodule

// File: rtl/gbuff_arbiter.sv
// Round-robin access controller for one single-port global buffer.
// Define GBUFF_ARB_CLEAR_EN to build the zero-fill sweep engine.
module gbuff_arbiter
   import gbuff_arb_pkg::*;
#(
   parameter int NUM_REQ   = NUM_REQ_DEF,
   parameter int ADDR_BITS = ADDR_BITS_DEF,
   parameter int DATA_BITS = DATA_BITS_DEF
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0]             req_we,
   input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_BITS-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [DATA_BITS-1:0]           rsp_data,
   input  logic                           clear_i,
   output logic                           busy_o,
   output logic                           gb_wr_en,
   output logic [ADDR_BITS-1:0]           gb_index,
   output logic [DATA_BITS-1:0]           gb_data_in,
   input  logic [DATA_BITS-1:0]           gb_data_out
);

   localparam int W = req_id_w(NUM_REQ);

   logic [W-1:0]       rr_ptr;
   logic [W-1:0]       gidx;
   logic [NUM_REQ-1:0] grant;
   logic               gany;
   logic               serve;
   logic               take;

   rr_arbiter #(
      .N (NUM_REQ),
      .W (W)
   ) u_rr (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (gidx),
      .any   (gany)
   );

`ifdef GBUFF_ARB_CLEAR_EN
   state_t               state;
   logic [ADDR_BITS-1:0] cnt;

   assign serve  = (state == SERVE);
   assign busy_o = ~serve;

   // The grant in the clear_i cycle still completes; sweep starts next cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= SERVE;
         cnt   <= '0;
      end else if (serve) begin
         cnt <= '0;
         if (clear_i) state <= CLEAR;
      end else begin
         cnt <= cnt + 1'b1;
         if (cnt == '1) state <= SERVE;
      end
   end
`else
   logic unused_clear;

   assign unused_clear = clear_i;
   assign serve        = 1'b1;
   assign busy_o       = 1'b0;
`endif

   assign take      = serve & gany;
   assign req_ready = serve ? grant : '0;
   assign rsp_data  = gb_data_out;

   always_comb begin
      gb_wr_en   = 1'b0;
      gb_index   = '0;
      gb_data_in = '0;
      if (take) begin
         gb_wr_en   = req_we[gidx];
         gb_index   = req_addr[gidx*ADDR_BITS +: ADDR_BITS];
         gb_data_in = req_wdata[gidx*DATA_BITS +: DATA_BITS];
      end
`ifdef GBUFF_ARB_CLEAR_EN
      if (!serve) begin
         gb_wr_en = 1'b1;
         gb_index = cnt;
      end
`endif
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr    <= '0;
         rsp_valid <= '0;
      end else begin
         rsp_valid <= take ? (grant & ~req_we) : '0;
         if (take) begin
            if (gidx == W'(NUM_REQ - 1)) rr_ptr <= '0;
            else                         rr_ptr <= gidx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_gbuff_arbiter.sv
// Scoreboard bench for gbuff_arbiter: directed stimulus, queued read
// responses checked by a separate monitor against a buffer model.
module tb_gbuff_arbiter;

   localparam int N  = 4;
   localparam int AB = 8;
   localparam int DB = 8;

   logic          clk = 1'b0;
   logic          rst_i;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_we;
   logic [N*AB-1:0] req_addr;
   logic [N*DB-1:0] req_wdata;
   logic [N-1:0]  req_ready;
   logic [N-1:0]  rsp_valid;
   logic [DB-1:0] rsp_data;
   logic          clear_i;
   logic          busy_o;
   logic          gb_wr_en;
   logic [AB-1:0] gb_index;
   logic [DB-1:0] gb_data_in;
   logic [DB-1:0] gb_data_out;

   logic [DB-1:0] mem [2**AB];

   typedef struct {
      logic [N-1:0]  who;
      logic [DB-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   gbuff_arbiter #(
      .NUM_REQ   (N),
      .ADDR_BITS (AB),
      .DATA_BITS (DB)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .req_valid   (req_valid),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .clear_i     (clear_i),
      .busy_o      (busy_o),
      .gb_wr_en    (gb_wr_en),
      .gb_index    (gb_index),
      .gb_data_in  (gb_data_in),
      .gb_data_out (gb_data_out)
   );

   always #5 clk = ~clk;

   // Single-port buffer with registered read data.
   always @(posedge clk) begin
      if (gb_wr_en) mem[gb_index] <= gb_data_in;
      gb_data_out <= mem[gb_index];
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_valid = '0;
      req_we    = '0;
   endtask

   task automatic put(input int r, input logic [AB-1:0] a,
                      input logic [DB-1:0] d);
      req_addr[r*AB +: AB]  = a;
      req_wdata[r*DB +: DB] = d;
   endtask

   task automatic push(input logic [N-1:0] who, input logic [DB-1:0] d);
      exp_t e;
      e.who  = who;
      e.data = d;
      sb.push_back(e);
   endtask

   // Monitor: every response strobe must match the oldest expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_i && rsp_valid != '0) begin
            if (sb.size() == 0) begin
               chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("rsp_who", 32'(rsp_valid), 32'(e.who));
               chk("rsp_data", 32'(rsp_data), 32'(e.data));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int cnt;
      int bad_r;
      int bad_i;
      logic [N-1:0] e1;

      rst_i     = 1'b1;
      clear_i   = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      idle();
      tick();
      tick();
      rst_i = 1'b0;

      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_busy", 32'(busy_o), 32'h0);
      chk("rst_wr_en", 32'(gb_wr_en), 32'h0);
      chk("rst_index", 32'(gb_index), 32'h0);
      chk("rst_data_in", 32'(gb_data_in), 32'h0);
      tick();

      // Write then later read of req 1 at 0x10.
      req_valid = 4'b0010;
      req_we    = 4'b0010;
      put(1, 8'h10, 8'hA5);
      @(negedge clk);
      chk("wr_ready", 32'(req_ready), 32'h2);
      chk("wr_en", 32'(gb_wr_en), 32'h1);
      chk("wr_index", 32'(gb_index), 32'h10);
      chk("wr_data_in", 32'(gb_data_in), 32'hA5);
      tick();
      idle();
      @(negedge clk);
      chk("idle_ready", 32'(req_ready), 32'h0);
      chk("idle_wr_en", 32'(gb_wr_en), 32'h0);
      chk("idle_index", 32'(gb_index), 32'h0);
      tick();
      req_valid = 4'b0010;
      req_we    = 4'b0000;
      @(negedge clk);
      chk("rd_ready", 32'(req_ready), 32'h2);
      chk("rd_wr_en", 32'(gb_wr_en), 32'h0);
      push(4'b0010, 8'hA5);
      tick();
      idle();
      tick();

      // Fresh pointer, then all four reads held for eight cycles.
      rst_i = 1'b1;
      #2;
      rst_i = 1'b0;
      for (int r = 0; r < N; r++) put(r, 8'h10, 8'h00);
      req_valid = 4'b1111;
      req_we    = 4'b0000;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         e1 = 4'b0001 << (c % 4);
         chk("rr_grant", 32'(req_ready), 32'(e1));
         push(e1, 8'hA5);
         tick();
      end
      idle();
      tick();

      // Back-to-back write by req 2 then read by req 0.
      req_valid = 4'b0100;
      req_we    = 4'b0100;
      put(2, 8'h05, 8'h3C);
      @(negedge clk);
      chk("b2b_wr_ready", 32'(req_ready), 32'h4);
      tick();
      req_valid = 4'b0001;
      req_we    = 4'b0000;
      put(0, 8'h05, 8'h00);
      @(negedge clk);
      chk("b2b_rd_ready", 32'(req_ready), 32'h1);
      push(4'b0001, 8'h3C);
      tick();
      idle();
      tick();

`ifdef GBUFF_ARB_CLEAR_EN
      for (int i = 0; i < 4; i++) begin
         req_valid = 4'b1000;
         req_we    = 4'b1000;
         put(3, 8'(i), 8'(8'h11 * (i + 1)));
         @(negedge clk);
         chk("fill_ready", 32'(req_ready), 32'h8);
         tick();
      end
      req_valid = 4'b0010;
      req_we    = 4'b0000;
      put(1, 8'h10, 8'h00);
      clear_i   = 1'b1;
      @(negedge clk);
      chk("pulse_ready", 32'(req_ready), 32'h2);
      push(4'b0010, 8'hA5);
      tick();
      clear_i   = 1'b0;
      req_valid = 4'b1111;
      cnt   = 0;
      bad_r = 0;
      bad_i = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (!busy_o) begin
            idle();
            break;
         end
         if (req_ready != '0) bad_r++;
         if (!gb_wr_en || gb_index != 8'(cnt) || gb_data_in != '0) bad_i++;
         cnt++;
         clear_i = (cnt == 100);
      end
      clear_i = 1'b0;
      idle();
      chk("sweep_len", 32'(cnt), 32'd256);
      chk("sweep_ready_zero", 32'(bad_r), 32'h0);
      chk("sweep_index", 32'(bad_i), 32'h0);
      tick();
      for (int i = 0; i < 4; i++) begin
         req_valid = 4'b0001;
         req_we    = 4'b0000;
         put(0, 8'(i), 8'h00);
         @(negedge clk);
         chk("post_ready", 32'(req_ready), 32'h1);
         push(4'b0001, 8'h00);
         tick();
      end
      idle();
      tick();
`endif

      // Async reset with a response pending (and mid-sweep when built).
      req_valid = 4'b0010;
      req_we    = 4'b0000;
      put(1, 8'h05, 8'h00);
      clear_i   = 1'b1;
      @(negedge clk);
      chk("ar_ready", 32'(req_ready), 32'h2);
      tick();
      clear_i = 1'b0;
      idle();
      chk("ar_pend_rsp", 32'(rsp_valid), 32'h2);
`ifdef GBUFF_ARB_CLEAR_EN
      chk("ar_pend_busy", 32'(busy_o), 32'h1);
`else
      chk("ar_pend_busy", 32'(busy_o), 32'h0);
`endif
      rst_i = 1'b1;
      #1;
      chk("ar_rsp_drop", 32'(rsp_valid), 32'h0);
      chk("ar_busy_drop", 32'(busy_o), 32'h0);
      chk("ar_wr_en", 32'(gb_wr_en), 32'h0);
      #1;
      rst_i     = 1'b0;
      req_valid = 4'b1111;
      req_we    = 4'b1111;
      for (int r = 0; r < N; r++) put(r, 8'h20, 8'h77);
      @(negedge clk);
      chk("ar_ptr_zero", 32'(req_ready), 32'h1);
      chk("ar_serve_index", 32'(gb_index), 32'h20);
      tick();
      idle();
      tick();
      tick();

      chk("sb_drain", 32'(sb.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
